// File: rtl/eeg_xram_rdr.sv
// ---------------------------------------------------------------------------
// eeg_xram_rdr
//
// Strided read engine for an external XRAM. A job is posted through the
// CFG handshake (start address, word count minus one, address increment).
// The engine issues LEN+1 read addresses (BASE, BASE+STRIDE, ... wrapping
// modulo 2^XRAM_ADD_AW). It buffers the returned words in a 2-entry FIFO
// and streams them out in order. DONE pulses once the last word has left
// the OUT port.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   CFG_VLD / CFG_RDY           job handshake (CFG_RDY high only when idle)
//   CFG_BASE/CFG_LEN/CFG_STRIDE job parameters, latched on acceptance
//   XRAM_ADD_*                  read-address request (VLD/LST/RDY/ADD)
//   XRAM_DAT_*                  read-data return (VLD/LST/RDY/DAT)
//   OUT_*                       downstream stream (VLD/LST/RDY/DAT)
//   BUSY                        a job is in progress
//   DONE                        one-cycle pulse after the last word is popped
// ---------------------------------------------------------------------------
module eeg_xram_rdr #(
    parameter int XRAM_ADD_AW = 12,
    parameter int XRAM_DAT_DW = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   CFG_VLD,
    output logic                   CFG_RDY,
    input  logic [XRAM_ADD_AW-1:0] CFG_BASE,
    input  logic [XRAM_ADD_AW-1:0] CFG_LEN,
    input  logic [XRAM_ADD_AW-1:0] CFG_STRIDE,

    output logic                   XRAM_ADD_VLD,
    output logic                   XRAM_ADD_LST,
    input  logic                   XRAM_ADD_RDY,
    output logic [XRAM_ADD_AW-1:0] XRAM_ADD_ADD,

    input  logic                   XRAM_DAT_VLD,
    input  logic                   XRAM_DAT_LST,
    output logic                   XRAM_DAT_RDY,
    input  logic [XRAM_DAT_DW-1:0] XRAM_DAT_DAT,

    output logic                   OUT_VLD,
    output logic                   OUT_LST,
    input  logic                   OUT_RDY,
    output logic [XRAM_DAT_DW-1:0] OUT_DAT,

    output logic                   BUSY,
    output logic                   DONE
);

    localparam logic [XRAM_ADD_AW-1:0] IDX_ONE = XRAM_ADD_AW'(1);
    localparam int                     FW      = XRAM_DAT_DW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 state_q;
    logic [XRAM_ADD_AW-1:0] addr_q;
    logic [XRAM_ADD_AW-1:0] idx_q;
    logic [XRAM_ADD_AW-1:0] len_q;
    logic [XRAM_ADD_AW-1:0] stride_q;
    logic                   done_q;

    logic [1:0]             cnt_q, cnt_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]          fifo_q [2];
    logic [FW-1:0]          head;

    logic                   add_fire;
    logic                   push;
    logic                   pop;

    // Control outputs are plain decodes of the state register.
    assign CFG_RDY      = (state_q == S_IDLE);
    assign BUSY         = (state_q != S_IDLE);
    assign XRAM_ADD_VLD = (state_q == S_ISSUE);
    assign XRAM_ADD_LST = XRAM_ADD_VLD && (idx_q == len_q);
    assign XRAM_ADD_ADD = addr_q;
    assign DONE         = done_q;
    assign add_fire     = XRAM_ADD_VLD && XRAM_ADD_RDY;

    // The XRAM ties its address-ready to our data-ready. So a full FIFO
    // also stops address issue, and the XRAM holds at most one extra word.
    assign XRAM_DAT_RDY = (cnt_q < 2'd2);
    assign push         = XRAM_DAT_VLD && XRAM_DAT_RDY;
    assign OUT_VLD      = (cnt_q != 2'd0);
    assign pop          = OUT_VLD && OUT_RDY;
    assign head         = fifo_q[rd_ptr_q];
    assign OUT_DAT      = head[XRAM_DAT_DW-1:0];
    assign OUT_LST      = head[XRAM_DAT_DW];

    // Job FSM. The address is a running accumulator: each accepted request
    // adds STRIDE, and the add wraps naturally at the register width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            idx_q    <= '0;
            len_q    <= '0;
            stride_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (CFG_VLD) begin
                        state_q  <= S_ISSUE;
                        addr_q   <= CFG_BASE;
                        idx_q    <= '0;
                        len_q    <= CFG_LEN;
                        stride_q <= CFG_STRIDE;
                    end
                end
                S_ISSUE: begin
                    if (add_fire) begin
                        addr_q <= addr_q + stride_q;
                        idx_q  <= idx_q + IDX_ONE;
                        if (idx_q == len_q) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // The word tagged LST is always the final one of the job.
                    if (pop && OUT_LST) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO pointer and occupancy next-state. A push and a pop in the same
    // cycle leave the count unchanged.
    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    // FIFO storage. Entries are cleared on reset so OUT_DAT/OUT_LST read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            fifo_q   <= '{default: '0};
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= {XRAM_DAT_LST, XRAM_DAT_DAT};
            end
        end
    end

endmodule
